hex_display_scanner: RTL and testbench

//  - Drives N time-multiplexed 7-segment hex digits from one packed value bus.
//  - Contains one shared segment decoder, a scan prescaler and a digit index counter.
//  - Updates are tear-free: a new value is committed only at a frame boundary.
//  - Optional leading-zero blanking. Sits between datapath registers and board HEX/anode pins.

---
 rtl/hex_display_pkg.sv | 17 +
 rtl/hex_seg_decoder.sv | 11 +
 rtl/hex_display_scanner.sv | 140 ++++++++++++++
 tb/tb_hex_display_scanner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: blank pattern, active-low
// segment table and the digit-index width helper.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry i is the active-low pattern for hex digit i (bit0=a .. bit6=g).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex display driver with frame-boundary commit and
// optional leading-zero blanking. Define BLINK_EN to add per-digit blinking.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int DIV_WIDTH      = 16,
    parameter int BLINK_DIV_LOG2 = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic                    load,
    input  logic                    lz_suppress,
`ifdef BLINK_EN
    input  logic [N_DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     digit_sel,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IDX_W = idx_width(N_DIGITS);

    if (N_DIGITS < 1 || SCAN_DIV < 1 || BLINK_DIV_LOG2 < 1 || DIV_WIDTH < 1) begin : g_bad_param
        $error("hex_display_scanner: invalid parameter");
    end

    logic [DIV_WIDTH-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [N_DIGITS-1:0]     digit_sel_q, digit_sel_d;
    logic                    frame_start_q, frame_start_d;

    logic                    scan_tc;
    logic                    commit;
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic [N_DIGITS-1:0]     upper_zero;
    logic                    zero_acc;
    logic                    blank;

`ifdef BLINK_EN
    logic [BLINK_DIV_LOG2-1:0] blink_q, blink_d;
`endif

    assign scan_tc    = (presc_q == DIV_WIDTH'(SCAN_DIV - 1));
    assign commit     = scan_tc && (idx_q == IDX_W'(N_DIGITS - 1));
    assign cur_nibble = disp_q[int'(idx_q)*4 +: 4];

    hex_seg_decoder u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        if (scan_tc) begin
            presc_d = '0;
            idx_d   = commit ? '0 : IDX_W'(idx_q + 1'b1);
        end else begin
            presc_d = DIV_WIDTH'(presc_q + 1'b1);
        end

        // A load landing on the commit edge goes straight to the display.
        if (load && commit) begin
            shadow_d  = value_in;
            disp_d    = value_in;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end else if (commit) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end

        // upper_zero[i]: nibbles i..N_DIGITS-1 of the displayed value are all zero.
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc && (disp_q[i*4 +: 4] == 4'h0);
            upper_zero[i] = zero_acc;
        end

        blank = lz_suppress && (idx_q != '0) && upper_zero[idx_q];
`ifdef BLINK_EN
        blink_d = BLINK_DIV_LOG2'(blink_q + 1'b1);
        if (blink_q[BLINK_DIV_LOG2-1] && blink_mask[idx_q]) blank = 1'b1;
`endif

        seg_d         = blank ? SEG_BLANK : dec_seg;
        digit_sel_d   = N_DIGITS'(1) << idx_q;
        frame_start_d = (presc_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_BLANK;
            digit_sel_q   <= '0;
            frame_start_q <= 1'b0;
`ifdef BLINK_EN
            blink_q       <= '0;
`endif
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
`ifdef BLINK_EN
            blink_q       <= blink_d;
`endif
        end
    end

    assign seg         = seg_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized bench for hex_display_scanner against a cycle-count reference model.
module tb_hex_display_scanner;

    localparam int N  = 4;
    localparam int SD = 3;
    localparam int BL = 3;
    localparam int FR = N * SD;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic        lz_suppress;
    logic [15:0] value_in;
`ifdef BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  seg;
    logic [3:0]  digit_sel;
    logic        frame_start;
    logic        pending;

    always #5 clock = ~clock;

    hex_display_scanner #(
        .N_DIGITS       (N),
        .SCAN_DIV       (SD),
        .DIV_WIDTH      (16),
        .BLINK_DIV_LOG2 (BL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .lz_suppress (lz_suppress),
`ifdef BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .seg         (seg),
        .digit_sel   (digit_sel),
        .frame_start (frame_start),
        .pending     (pending)
    );

    int checks   = 0;
    int failures = 0;

    // Model: k = edges since reset release; everything else follows from it.
    int          k;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_fs;
    logic [6:0]  lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int d);
        logic [15:0] upper;
        upper = m_disp >> (4 * d);
        if (lz_suppress && d > 0 && upper == 16'h0) return 7'h7F;
`ifdef BLINK_EN
        if (blink_mask[d] && ((k >> (BL - 1)) & 1) == 1) return 7'h7F;
`endif
        return lut[upper[3:0]];
    endfunction

    task automatic step(input logic rst, input logic ld, input logic [15:0] v);
        int   d;
        logic cmt;
        reset    = rst;
        load     = ld;
        value_in = v;
        @(posedge clock);
        if (rst) begin
            k = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
            e_seg = 7'h7F; e_sel = '0; e_fs = 1'b0;
        end else begin
            d     = (k / SD) % N;
            e_sel = 4'(1 << d);
            e_fs  = (k % FR) == 0;
            e_seg = ref_seg(d);
            cmt   = (k % FR) == FR - 1;
            if (ld && cmt) begin
                m_disp = v; m_shadow = v; m_pend = 1'b0;
            end else if (ld) begin
                m_shadow = v; m_pend = 1'b1;
            end else if (cmt) begin
                m_disp = m_shadow; m_pend = 1'b0;
            end
            k++;
        end
        #1;
        chk("seg", seg, e_seg);
        chk("digit_sel", digit_sel, e_sel);
        chk("frame_start", frame_start, e_fs);
        chk("pending", pending, m_pend);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; value_in = '0; lz_suppress = 1'b0;
        k = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
`ifdef BLINK_EN
        blink_mask = 4'b0100;
`endif
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_sel", digit_sel, 4'b0000);

        step(1'b0, 1'b0, 16'h0);
        chk("first_sel", digit_sel, 4'b0001);
        repeat (6) step(1'b0, 1'b0, 16'h0);

        // Mid-frame load: held in shadow until the wrap.
        step(1'b0, 1'b1, 16'hA1F8);
        chk("load_pending", pending, 1'b1);
        repeat (30) step(1'b0, 1'b0, 16'h0);

        // Two loads in one frame: only the last survives.
        step(1'b0, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h2222);
        repeat (30) step(1'b0, 1'b0, 16'h0);

        // Load exactly on the commit edge.
        for (int i = 0; i < FR && (k % FR) != FR - 1; i++) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0000);
        chk("commit_load_pending", pending, 1'b0);
        repeat (26) step(1'b0, 1'b0, 16'h0);

        lz_suppress = 1'b1;
        step(1'b0, 1'b1, 16'h0050);
        repeat (30) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0000);
        repeat (30) step(1'b0, 1'b0, 16'h0);
        lz_suppress = 1'b0;

        // Reset mid-frame with pending data.
        step(1'b0, 1'b1, 16'h9876);
        step(1'b1, 1'b0, 16'h0);
        chk("midreset_pending", pending, 1'b0);
        repeat (30) step(1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 600; i++) begin
            lz_suppress = 1'($urandom_range(0, 1));
`ifdef BLINK_EN
            blink_mask = 4'($urandom_range(0, 15));
`endif
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
